// File: rtl/xy_drv_pkg.sv
// Shared state codes and status encodings for the x/y sequence driver.
package xy_drv_pkg;

    typedef logic [3:0] state_t;
    typedef logic [7:0] cnt_t;

    localparam state_t S_IDLE    = 4'd0;
    localparam state_t S_GAP     = 4'd1;
    localparam state_t S_PRE     = 4'd2;
    localparam state_t S_P1A     = 4'd3;
    localparam state_t S_P0      = 4'd4;
    localparam state_t S_P1B     = 4'd5;
    localparam state_t S_WAIT_G  = 4'd6;
    localparam state_t S_Y_DLY   = 4'd7;
    localparam state_t S_Y_ON    = 4'd8;
    localparam state_t S_CHECK   = 4'd9;
    localparam state_t S_PASS    = 4'd10;
    localparam state_t S_DENIED  = 4'd11;
    localparam state_t S_TIMEOUT = 4'd12;

    localparam logic [1:0] ST_BUSY    = 2'b00;
    localparam logic [1:0] ST_PASS    = 2'b01;
    localparam logic [1:0] ST_DENIED  = 2'b10;
    localparam logic [1:0] ST_TIMEOUT = 2'b11;

endpackage

// File: rtl/xy_sequence_driver_if.sv
// f/g/x/y bundle between the sequence driver (master) and the motor-enable controller (slave).
interface xy_sequence_driver_if;

    logic       f;
    logic       g;
    logic       x;
    logic       y;
    logic       done;
    logic [1:0] status;

    modport master (
        input  f,
        input  g,
        output x,
        output y,
        output done,
        output status
    );

    modport slave (
        output f,
        output g,
        input  x,
        input  y,
        input  done,
        input  status
    );

endinterface

// File: rtl/xy_sequence_driver.sv
// Stimulus peer of the motor-enable FSM: drives x=1,0,1 after f, answers g on y, reports result.
// Optional XY_DRV_PREAMBLE_EN inserts an extra x=1 cycle (PRE) ahead of the pattern.
module xy_sequence_driver
    import xy_drv_pkg::*;
#(
    parameter int unsigned PRE_GAP   = 2,
    parameter int unsigned Y_DELAY   = 0,
    parameter int unsigned Y_HOLD    = 1,
    parameter int unsigned G_TIMEOUT = 8
) (
    input  logic                 clk,
    input  logic                 resetn,
    xy_sequence_driver_if.master bus
);

`ifdef XY_DRV_PREAMBLE_EN
    localparam state_t PatternStart = S_PRE;
`else
    localparam state_t PatternStart = S_P1A;
`endif

    localparam state_t LaunchState = (PRE_GAP > 0) ? S_GAP : PatternStart;
    localparam state_t AfterGrant  = (Y_DELAY > 0) ? S_Y_DLY : S_Y_ON;

    localparam cnt_t GapLast  = cnt_t'(PRE_GAP - 1);
    localparam cnt_t DlyLast  = cnt_t'(Y_DELAY - 1);
    localparam cnt_t HoldLast = cnt_t'(Y_HOLD - 1);
    localparam cnt_t ToLast   = cnt_t'(G_TIMEOUT - 1);

    state_t state_q, state_d;
    cnt_t   cnt_q, cnt_d;
    logic   restart;
    logic   counting;

    // f anywhere but IDLE aborts; in GAP this lands back in GAP with the count cleared.
    assign restart = bus.f && (state_q != S_IDLE);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (bus.f) state_d = LaunchState;
            S_GAP:     if (cnt_q == GapLast) state_d = PatternStart;
            S_PRE:     state_d = S_P1A;
            S_P1A:     state_d = S_P0;
            S_P0:      state_d = S_P1B;
            S_P1B:     state_d = S_WAIT_G;
            S_WAIT_G: begin
                if (bus.g) begin
                    state_d = AfterGrant;
                end else if (cnt_q == ToLast) begin
                    state_d = S_TIMEOUT;
                end
            end
            S_Y_DLY:   if (cnt_q == DlyLast) state_d = S_Y_ON;
            S_Y_ON:    if (cnt_q == HoldLast) state_d = S_CHECK;
            S_CHECK:   state_d = bus.g ? S_PASS : S_DENIED;
            S_PASS,
            S_DENIED,
            S_TIMEOUT: state_d = state_q;
            default:   state_d = S_IDLE;
        endcase
        if (restart) begin
            state_d = LaunchState;
        end
    end

    assign counting = (state_q == S_GAP) || (state_q == S_WAIT_G) ||
                      (state_q == S_Y_DLY) || (state_q == S_Y_ON);

    always_comb begin
        cnt_d = cnt_q;
        if (restart || (state_d != state_q)) begin
            cnt_d = '0;
        end else if (counting && (cnt_q != 8'hFF)) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        bus.x      = (state_q == S_PRE) || (state_q == S_P1A) || (state_q == S_P1B);
        bus.y      = (state_q == S_Y_ON);
        bus.done   = 1'b0;
        bus.status = ST_BUSY;
        case (state_q)
            S_PASS: begin
                bus.done   = 1'b1;
                bus.status = ST_PASS;
            end
            S_DENIED: begin
                bus.done   = 1'b1;
                bus.status = ST_DENIED;
            end
            S_TIMEOUT: begin
                bus.done   = 1'b1;
                bus.status = ST_TIMEOUT;
            end
            default: begin
                bus.done   = 1'b0;
                bus.status = ST_BUSY;
            end
        endcase
    end

endmodule

// File: tb/tb_xy_sequence_driver.sv
// Directed bench for xy_sequence_driver: two instances with different timing, scoreboarded outputs.
module tb_xy_sequence_driver;
    import xy_drv_pkg::*;

    logic clk = 1'b0;
    logic resetn;

    always #5 clk = ~clk;

    xy_sequence_driver_if ifa ();
    xy_sequence_driver_if ifb ();

    xy_sequence_driver #(
        .PRE_GAP   (0),
        .Y_DELAY   (0),
        .Y_HOLD    (1),
        .G_TIMEOUT (8)
    ) dut_a (
        .clk    (clk),
        .resetn (resetn),
        .bus    (ifa)
    );

    xy_sequence_driver #(
        .PRE_GAP   (2),
        .Y_DELAY   (1),
        .Y_HOLD    (2),
        .G_TIMEOUT (8)
    ) dut_b (
        .clk    (clk),
        .resetn (resetn),
        .bus    (ifb)
    );

    // Expected outputs packed as {x, y, done, status}.
    localparam logic [4:0] O_IDLE = 5'b00000;
    localparam logic [4:0] O_X    = 5'b10000;
    localparam logic [4:0] O_Y    = 5'b01000;
    localparam logic [4:0] O_PASS = {3'b001, ST_PASS};
    localparam logic [4:0] O_DEN  = {3'b001, ST_DENIED};
    localparam logic [4:0] O_TO   = {3'b001, ST_TIMEOUT};

    typedef struct {
        bit         sel;
        logic [4:0] exp;
        string      tag;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    function automatic logic [4:0] obs(input bit sel);
        if (sel) return {ifb.x, ifb.y, ifb.done, ifb.status};
        return {ifa.x, ifa.y, ifa.done, ifa.status};
    endfunction

    task automatic push(input bit sel, input logic [4:0] e, input string tag);
        exp_t it;
        it.sel = sel;
        it.exp = e;
        it.tag = tag;
        sb.push_back(it);
    endtask

    task automatic tick();
        exp_t       it;
        logic [4:0] o;
        @(posedge clk);
        #1;
        while (sb.size() > 0) begin
            it = sb.pop_front();
            o  = obs(it.sel);
            vectors++;
            assert (o === it.exp) else begin
                miscompares++;
                $error("FAIL %s: observed x/y/done/status=%b expected %b", it.tag, o, it.exp);
            end
        end
    endtask

    task automatic step(input bit sel, input logic [4:0] e, input string tag);
        push(sel, e, tag);
        tick();
    endtask

    // First edge samples f (already raised by the caller); f is dropped after it.
    task automatic pattern(input bit sel, input string tag);
`ifdef XY_DRV_PREAMBLE_EN
        step(sel, O_X, {tag, "_pre"});
        ifa.f = 1'b0;
        ifb.f = 1'b0;
`endif
        step(sel, O_X, {tag, "_p1a"});
        ifa.f = 1'b0;
        ifb.f = 1'b0;
        step(sel, O_IDLE, {tag, "_p0"});
        step(sel, O_X, {tag, "_p1b"});
        step(sel, O_IDLE, {tag, "_waitg"});
    endtask

    initial begin
        resetn = 1'b0;
        ifa.f  = 1'b0;
        ifa.g  = 1'b0;
        ifb.f  = 1'b0;
        ifb.g  = 1'b0;
        push(1'b0, O_IDLE, "rst_a");
        push(1'b1, O_IDLE, "rst_b");
        tick();
        tick();
        resetn = 1'b1;
        step(1'b0, O_IDLE, "idle_a");

        // Grant held: PASS.
        ifa.f = 1'b1;
        pattern(1'b0, "t1");
        ifa.g = 1'b1;
        step(1'b0, O_Y, "t1_yon");
        step(1'b0, O_IDLE, "t1_check");
        step(1'b0, O_PASS, "t1_pass");
        step(1'b0, O_PASS, "t1_sticky");

        // Late y: controller drops g as y rises, DENIED.
        ifb.f = 1'b1;
        step(1'b1, O_IDLE, "t2_gap0");
        ifb.f = 1'b0;
        step(1'b1, O_IDLE, "t2_gap1");
        pattern(1'b1, "t2");
        ifb.g = 1'b1;
        step(1'b1, O_IDLE, "t2_ydly");
        ifb.g = 1'b0;
        step(1'b1, O_Y, "t2_yon0");
        step(1'b1, O_Y, "t2_yon1");
        step(1'b1, O_IDLE, "t2_check");
        step(1'b1, O_DEN, "t2_denied");

        // g never comes: exactly 8 WAIT_G cycles then TIMEOUT.
        ifa.g = 1'b0;
        ifa.f = 1'b1;
        pattern(1'b0, "t3");
        for (int i = 0; i < 7; i++) step(1'b0, O_IDLE, "t3_waitg");
        step(1'b0, O_TO, "t3_timeout");
        step(1'b0, O_TO, "t3_sticky");

        // f in WAIT_G restarts; f held into GAP restarts the gap count.
        ifb.f = 1'b1;
        step(1'b1, O_IDLE, "t4_gap0");
        ifb.f = 1'b0;
        step(1'b1, O_IDLE, "t4_gap1");
        pattern(1'b1, "t4a");
        step(1'b1, O_IDLE, "t4_waitg1");
        step(1'b1, O_IDLE, "t4_waitg2");
        ifb.f = 1'b1;
        step(1'b1, O_IDLE, "t4_rgap0");
        step(1'b1, O_IDLE, "t4_rgap0b");
        ifb.f = 1'b0;
        step(1'b1, O_IDLE, "t4_rgap1");
        pattern(1'b1, "t4b");
        ifb.g = 1'b1;
        step(1'b1, O_IDLE, "t4_ydly");
        step(1'b1, O_Y, "t4_yon0");
        step(1'b1, O_Y, "t4_yon1");
        step(1'b1, O_IDLE, "t4_check");
        step(1'b1, O_PASS, "t4_pass");

        // g on the last WAIT_G cycle beats the timeout.
        ifb.g = 1'b0;
        ifb.f = 1'b1;
        step(1'b1, O_IDLE, "t5_gap0");
        ifb.f = 1'b0;
        step(1'b1, O_IDLE, "t5_gap1");
        pattern(1'b1, "t5");
        for (int i = 0; i < 7; i++) step(1'b1, O_IDLE, "t5_waitg");
        ifb.g = 1'b1;
        step(1'b1, O_IDLE, "t5_ydly");
        step(1'b1, O_Y, "t5_yon");

        // Reset while in Y_ON aborts to idle outputs.
        ifa.f = 1'b1;
        pattern(1'b0, "t6");
        ifa.g = 1'b1;
        step(1'b0, O_Y, "t6_yon");
        resetn = 1'b0;
        push(1'b0, O_IDLE, "t6_rst_a");
        push(1'b1, O_IDLE, "t6_rst_b");
        tick();
        resetn = 1'b1;
        ifa.g  = 1'b0;
        ifb.g  = 1'b0;
        push(1'b0, O_IDLE, "t6_idle_a");
        push(1'b1, O_IDLE, "t6_idle_b");
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
